// File: rtl/calc_pkg.sv
// Shared encodings for the calculator sequencing controller: FSM states,
// keypad key types and display-select codes.
package calc_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EQ   = 3'd3,
        S_EXEC = 3'd4,
        S_RES  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        KEY_OPND = 2'b00,
        KEY_OPR  = 2'b01,
        KEY_EQ   = 2'b10,
        KEY_CLR  = 2'b11
    } key_t;

    typedef enum logic [1:0] {
        DISP_A   = 2'd0,
        DISP_B   = 2'd1,
        DISP_RES = 2'd2,
        DISP_ERR = 2'd3
    } disp_t;

endpackage

// File: rtl/calc_seq_if.sv
// Keypad/datapath bundle between the keypad decoder, the register/ALU datapath
// and the calc_seq controller.
interface calc_seq_if #(
    parameter int N   = 8,
    parameter int OPW = 2
);
    logic           key_vld;
    logic [1:0]     key_type;
    logic [N-1:0]   key_data;
    logic           div_zero;
    logic           opa_ld0;
    logic           opa_ld1;
    logic           opb_ld0;
    logic           res_ld0;
    logic [OPW-1:0] op_q;
    logic           busy;
    logic           err;
    logic [1:0]     disp_sel;

    modport master (
        output key_vld, key_type, key_data, div_zero,
        input  opa_ld0, opa_ld1, opb_ld0, res_ld0, op_q, busy, err, disp_sel
    );

    modport slave (
        input  key_vld, key_type, key_data, div_zero,
        output opa_ld0, opa_ld1, opb_ld0, res_ld0, op_q, busy, err, disp_sel
    );
endinterface

// File: rtl/calc_lat_cnt.sv
// Loadable down-counter timing the fixed-latency ALU; saturates at zero and
// reports a zero flag.
module calc_lat_cnt #(
    parameter  int unsigned ALU_LAT = 2,
    localparam int unsigned CW      = $clog2(ALU_LAT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= CW'(ALU_LAT - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/calc_seq.sv
// Keypad-driven sequencing controller for the calculator datapath.
// Optional macro CALC_CHAIN_EN: operator key in S_RES chains the result into A.
module calc_seq
    import calc_pkg::*;
#(
    parameter int          N       = 8,
    parameter int          OPW     = 2,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    calc_seq_if.slave  bus
);

    localparam int unsigned CW = $clog2(ALU_LAT + 1);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           err_q, err_d;
    disp_t          disp_q, disp_d;

    logic           cnt_clr, cnt_ld, cnt_en, cnt_zero;
    logic [CW-1:0]  cnt;

    logic           is_opnd, is_opr, is_eq, is_clr;
    logic           unused_key;

    assign is_opnd = bus.key_vld && (bus.key_type == KEY_OPND);
    assign is_opr  = bus.key_vld && (bus.key_type == KEY_OPR);
    assign is_eq   = bus.key_vld && (bus.key_type == KEY_EQ);
    assign is_clr  = bus.key_vld && (bus.key_type == KEY_CLR);

    // Only the low OPW bits of key_data carry an operator; operands go straight to the datapath.
    assign unused_key = ^{1'b0, bus.key_data[N-1:0]};

    calc_lat_cnt #(.ALU_LAT(ALU_LAT)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .ld   (cnt_ld),
        .en   (cnt_en),
        .cnt  (cnt),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            op_q    <= '0;
            err_q   <= 1'b0;
            disp_q  <= DISP_A;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        err_d       = err_q;
        disp_d      = disp_q;
        cnt_clr     = 1'b0;
        cnt_ld      = 1'b0;
        cnt_en      = 1'b0;
        bus.opa_ld0 = 1'b0;
        bus.opa_ld1 = 1'b0;
        bus.opb_ld0 = 1'b0;
        bus.res_ld0 = 1'b0;

        if (is_clr) begin
            state_d = S_A;
            op_d    = '0;
            err_d   = 1'b0;
            disp_d  = DISP_A;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                S_A: begin
                    if (is_opnd) begin
                        bus.opa_ld0 = 1'b1;
                        state_d     = S_OP;
                        disp_d      = DISP_A;
                    end
                end
                S_OP: begin
                    if (is_opnd) begin
                        bus.opa_ld0 = 1'b1;
                    end else if (is_opr) begin
                        op_d    = bus.key_data[OPW-1:0];
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (is_opnd) begin
                        bus.opb_ld0 = 1'b1;
                        state_d     = S_EQ;
                        disp_d      = DISP_B;
                    end else if (is_opr) begin
                        op_d = bus.key_data[OPW-1:0];
                    end
                end
                S_EQ: begin
                    if (is_opnd) begin
                        bus.opb_ld0 = 1'b1;
                    end else if (is_opr) begin
                        op_d = bus.key_data[OPW-1:0];
                    end else if (is_eq) begin
                        state_d = S_EXEC;
                        cnt_ld  = 1'b1;
                    end
                end
                S_EXEC: begin
                    cnt_en = 1'b1;
                    if (cnt_zero) begin
                        if (bus.div_zero) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                            disp_d  = DISP_ERR;
                        end else begin
                            bus.res_ld0 = 1'b1;
                            state_d     = S_RES;
                            disp_d      = DISP_RES;
                        end
                    end
                end
                S_RES: begin
                    if (is_opnd) begin
                        bus.opa_ld0 = 1'b1;
                        state_d     = S_OP;
                        disp_d      = DISP_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_opr) begin
                        bus.opa_ld1 = 1'b1;
                        op_d        = bus.key_data[OPW-1:0];
                        state_d     = S_B;
                        disp_d      = DISP_A;
                    end
`endif
                end
                S_ERR: begin
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    assign bus.op_q     = op_q;
    assign bus.busy     = (state_q == S_EXEC);
    assign bus.err      = err_q;
    assign bus.disp_sel = disp_q;

endmodule

// File: doc/calc_seq.md
Name: calc_seq

Overview:
Keypad-driven sequencing controller for the calculator datapath.
- Decodes one-cycle key strobes.
- Drives the two-source load enables of the operand A, operand B and result registers (load port 0 = keypad/ALU path, load port 1 = chained result).
- Latches the operator, times the fixed-latency ALU and selects what the display shows.
- Sits between the keypad decoder and the register/ALU datapath.

Parameters:
N, 8, data width of key_data (unused internally except for port width)
OPW, 2, operator code width
ALU_LAT, 2, ALU latency in cycles; legal range >=1

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
key_vld  in  1  one-cycle key strobe
key_type  in  2  00 operand, 01 operator, 10 equals, 11 clear
key_data  in  N  operand value or operator code (low OPW bits)
div_zero  in  1  ALU divide-by-zero flag, valid in last EXEC cycle
opa_ld0  out  1  load A from keypad
opa_ld1  out  1  load A from result register (chaining)
opb_ld0  out  1  load B from keypad
res_ld0  out  1  load result from ALU
op_q  out  OPW  latched operator to ALU
busy  out  1  ALU computation in progress
err  out  1  error latched
disp_sel  out  2  0 = A, 1 = B, 2 = result, 3 = error pattern

Behaviour:
- Single clock clk; synchronous active-high rst.
- Reset: state S_A, op_q=0, busy=0, err=0, disp_sel=0, all load strobes 0, counter 0. Reset overrides everything, including mid-EXEC.
- Load strobes are Mealy: asserted combinationally in the same cycle as the accepted key_vld, so registers capture key_data on that edge. Each strobe lasts exactly one cycle.
- opa_ld0 and opa_ld1 are never asserted together.
- State, op_q, counter, err and disp_sel are registered.
- Clear key (key_vld & type 11) in any state, including S_EXEC and S_ERR:
  - next state S_A; op_q=0; err=0; counter=0; disp_sel=0.
  - no load strobe in that cycle.
- S_A (await A):
  - operand -> opa_ld0, go to S_OP, disp_sel=0.
  - operator/equals ignored.
- S_OP (A held):
  - operand -> opa_ld0, stay (overwrite A).
  - operator -> op_q<=key_data[OPW-1:0], go to S_B.
  - equals ignored.
- S_B (await B):
  - operand -> opb_ld0, go to S_EQ, disp_sel=1.
  - operator -> overwrite op_q, stay.
  - equals ignored.
- S_EQ (B held):
  - operand -> opb_ld0, stay.
  - operator -> overwrite op_q, stay.
  - equals -> go to S_EXEC, counter<=ALU_LAT-1.
- S_EXEC:
  - busy=1; non-clear keys dropped; counter decrements each cycle; state lasts exactly ALU_LAT cycles.
  - On the cycle with counter==0 and div_zero=1: go to S_ERR, err<=1, disp_sel<=3, no res_ld0.
  - On the cycle with counter==0 and div_zero=0: res_ld0=1, go to S_RES, disp_sel<=2.
- S_RES:
  - operand -> opa_ld0, go to S_OP, disp_sel=0 (fresh calculation).
  - operator -> see Optional Feature.
  - equals ignored.
- S_ERR: all keys except clear ignored; err stays 1.
- Counter width: $clog2(ALU_LAT+1); counter never wraps below 0.
- Simultaneous events: only one key per cycle by construction. Clear has priority over every other condition except rst.

Optional Feature:
Macro CALC_CHAIN_EN.
- Defined: operator key in S_RES asserts opa_ld1 (result copied into A), latches op_q, goes to S_B, disp_sel=0.
- Undefined: operator in S_RES is ignored; opa_ld1 is tied 0.

Decomposition:
- Package calc_pkg holds:
  - state encoding (S_A, S_OP, S_B, S_EQ, S_EXEC, S_RES, S_ERR);
  - key_type codes (KEY_OPND, KEY_OPR, KEY_EQ, KEY_CLR);
  - disp_sel codes.
- One natural sub-module: calc_lat_cnt, a loadable down-counter with zero flag, parameterised by ALU_LAT.
- Everything else stays in the FSM.

Test Plan:
1. ALU_LAT=2; operand 5, operator 2, operand 3, equals:
   - opa_ld0, then opb_ld0 pulse in the key cycles; op_q=2.
   - busy high for exactly 2 cycles; res_ld0 in the 2nd busy cycle.
   - then disp_sel=2, state S_RES.
2. Same sequence with div_zero=1 in the last EXEC cycle:
   - no res_ld0; err=1, disp_sel=3.
   - operand key ignored; clear -> err=0, disp_sel=0.
3. Clear in the 1st EXEC cycle: busy drops next cycle, no res_ld0, op_q=0, state S_A.
4. Operand 7 then operand 9 in S_OP: two opa_ld0 pulses. Operator 1 then operator 3 in S_B: op_q=3.
5. In S_RES, operator 1:
   - with CALC_CHAIN_EN: opa_ld1 one cycle, op_q=1, next operand gives opb_ld0.
   - without CALC_CHAIN_EN: no strobe, state unchanged.
6. rst asserted mid-EXEC and mid-S_B: next cycle all outputs at reset values, state S_A.
